// File: rtl/CPU_PKG.sv
// Shared types for the posted-write buffer in front of the bus state controller.
package CPU_PKG;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        PASS
    } wbuf_state_e;

    // External area is 00?00 in A[31:27]; bit 29 is a don't-care.
    localparam logic [4:0] EXT_MASK  = 5'b11011;
    localparam logic [4:0] EXT_MATCH = 5'b00000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] di;
        logic [3:0]  ba;
    } wbuf_entry_t;

    function automatic logic is_ext(input logic [31:0] addr);
        return (addr[31:27] & EXT_MASK) == EXT_MATCH;
    endfunction

endpackage

// File: rtl/bsc_wbuf_fifo.sv
// Posted-write storage: DEPTH x 68-bit entries, head readable with no latency.
module bsc_wbuf_fifo
    import CPU_PKG::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  wbuf_entry_t   wdata_i,
    output wbuf_entry_t   head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    wbuf_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (ce_i) begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ce_i && push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bsc_wbuf.sv
// Write buffer between CPU and bus state controller: posts external-area
// writes and holds every other access until the buffer has drained.
module bsc_wbuf
    import CPU_PKG::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DI,
    output logic [31:0] CPU_DO,
    input  logic [3:0]  CPU_BA,
    input  logic        CPU_WE,
    input  logic        CPU_REQ,
    input  logic        CPU_LOCK,
    output logic        CPU_BUSY,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    output logic        IBUS_LOCK,
    input  logic [31:0] IBUS_DO,
    input  logic        IBUS_BUSY
);

    localparam int CW = $clog2(DEPTH) + 1;

    wbuf_state_e   state_q;
    logic          seen_busy_q;
    logic          req_q;
    logic          we_q;
    logic          lock_q;
    logic [31:0]   a_q;
    logic [31:0]   di_q;
    logic [3:0]    ba_q;

    wbuf_entry_t   wdata;
    wbuf_entry_t   head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          postable;
    logic          done;
    logic          push;
    logic          pop;

    assign postable = CPU_REQ & CPU_WE & ~CPU_LOCK & is_ext(CPU_A);
    assign done     = req_q & ~IBUS_BUSY & seen_busy_q;
    assign push     = CE_R & postable & ~full & (state_q != PASS);
    assign pop      = CE_R & done & (state_q == DRAIN);
    assign wdata    = '{a: CPU_A, di: CPU_DI, ba: CPU_BA};

    bsc_wbuf_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_i  (RST),
        .ce_i   (CE_R),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(wdata),
        .head_o (head),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );

    // A full buffer stalls a post even if the head pops this same cycle.
    always_comb begin
        CPU_BUSY = 1'b0;
        if (CPU_REQ) begin
            if (state_q == PASS) begin
                CPU_BUSY = ~done;
            end else if (postable) begin
                CPU_BUSY = full;
            end else begin
                CPU_BUSY = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            seen_busy_q <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            a_q         <= '0;
            di_q        <= '0;
            ba_q        <= '0;
        end else if (CE_R) begin
            if (done) begin
                seen_busy_q <= 1'b0;
            end else if (req_q && IBUS_BUSY) begin
                seen_busy_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= DRAIN;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        lock_q  <= 1'b0;
                        a_q     <= head.a;
                        di_q    <= head.di;
                        ba_q    <= head.ba;
                    end else if (CPU_REQ && !postable) begin
                        state_q <= PASS;
                        req_q   <= 1'b1;
                        we_q    <= CPU_WE;
                        lock_q  <= CPU_LOCK;
                        a_q     <= CPU_A;
                        di_q    <= CPU_DI;
                        ba_q    <= CPU_BA;
                    end
                end
                DRAIN: begin
                    // One idle cycle between entries lets the next head settle.
                    if (done) begin
                        req_q <= 1'b0;
                        if (count == CW'(1) && !push) begin
                            state_q <= IDLE;
                        end
                    end else if (!req_q) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b1;
                        lock_q <= 1'b0;
                        a_q    <= head.a;
                        di_q   <= head.di;
                        ba_q   <= head.ba;
                    end
                end
                PASS: begin
                    if (done) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IBUS_A    = a_q;
    assign IBUS_DI   = di_q;
    assign IBUS_BA   = ba_q;
    assign IBUS_WE   = we_q;
    assign IBUS_REQ  = req_q;
    assign IBUS_LOCK = lock_q;
    assign CPU_DO    = IBUS_DO;

endmodule
